// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low glyph table and blank pattern.
// Glyph index equals the hex value the pattern represents.
package seg7_pkg;

    localparam int GLYPH_CNT = 16;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    localparam logic [6:0] SEG7_GLYPH [GLYPH_CNT] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic       err;
        logic [3:0] nibble;
    } glyph_dec_t;

    // Patterns outside the table decode to nibble 0 with err set.
    function automatic glyph_dec_t glyph_lookup(input logic [6:0] pat);
        glyph_dec_t res;
        res.err    = 1'b1;
        res.nibble = 4'h0;
        for (int i = 0; i < GLYPH_CNT; i++) begin
            if (pat == SEG7_GLYPH[i]) begin
                res.err    = 1'b0;
                res.nibble = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup of an active-low 7-segment pattern to a hex nibble.
// err flags any pattern that is not one of the sixteen legal glyphs.
module seg7_glyph_decode (
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       err
);
    import seg7_pkg::*;

    glyph_dec_t dec_s;

    // Table lookup
    always_comb begin
        dec_s = glyph_lookup(seg_n);
    end

    assign nibble = dec_s.nibble;
    assign err    = dec_s.err;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: waits for each digit to dwell stably, decodes it,
// and emits a full frame on a valid/ready port. Optional input synchronizer: SEG7_DEC_SYNC_EN.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                seg_n,
    input  logic [NUM_DIGITS-1:0]     an_n,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*NUM_DIGITS-1:0]   out_hex,
    output logic [NUM_DIGITS-1:0]     out_dot,
    output logic [NUM_DIGITS-1:0]     out_err,
    output logic                      overrun
);
    import seg7_pkg::*;

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [7:0]        SEG_IDLE = {1'b1, SEG7_BLANK};

    logic [7:0]              seg_s;
    logic [NUM_DIGITS-1:0]   an_s;

`ifdef SEG7_DEC_SYNC_EN
    logic [7:0]              seg_meta_r;
    logic [7:0]              seg_sync_r;
    logic [NUM_DIGITS-1:0]   an_meta_r;
    logic [NUM_DIGITS-1:0]   an_sync_r;

    // Two-flop synchronizer; idles at all-ones so reset looks like a blanked bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta_r <= '1;
            seg_sync_r <= '1;
            an_meta_r  <= '1;
            an_sync_r  <= '1;
        end else begin
            seg_meta_r <= seg_n;
            seg_sync_r <= seg_meta_r;
            an_meta_r  <= an_n;
            an_sync_r  <= an_meta_r;
        end
    end

    assign seg_s = seg_sync_r;
    assign an_s  = an_sync_r;
`else
    assign seg_s = seg_n;
    assign an_s  = an_n;
`endif

    logic [7:0]              prev_seg_r;
    logic [NUM_DIGITS-1:0]   prev_an_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [NUM_DIGITS-1:0]   an_low_s;
    logic                    onehot_s;
    logic                    same_s;
    logic [CNT_W-1:0]        cnt_next_s;
    logic                    capture_s;
    logic [NUM_DIGITS-1:0]   cap_oh_s;

    // Stability counter: capture fires once, on the step into CNT_MAX
    always_comb begin
        an_low_s   = ~an_s;
        onehot_s   = (an_low_s != '0) &&
                     ((an_low_s & (an_low_s - NUM_DIGITS'(1))) == '0);
        same_s     = (seg_s == prev_seg_r) && (an_s == prev_an_r);
        cnt_next_s = '0;
        capture_s  = 1'b0;
        if (!onehot_s) begin
            cnt_next_s = '0;
        end else if (same_s) begin
            if (cnt_r == CNT_MAX) begin
                cnt_next_s = CNT_MAX;
            end else begin
                cnt_next_s = cnt_r + CNT_ONE;
                capture_s  = (cnt_r == CNT_MAX - CNT_ONE);
            end
        end else begin
            cnt_next_s = CNT_ONE;
            capture_s  = (CNT_MAX == CNT_ONE);
        end
        if (capture_s) begin
            cap_oh_s = an_low_s;
        end else begin
            cap_oh_s = '0;
        end
    end

    // Previous-sample and dwell counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_seg_r <= SEG_IDLE;
            prev_an_r  <= '1;
            cnt_r      <= '0;
        end else begin
            prev_seg_r <= seg_s;
            prev_an_r  <= an_s;
            cnt_r      <= cnt_next_s;
        end
    end

    logic [3:0]              dec_nib_s;
    logic                    dec_err_s;

    seg7_glyph_decode u_glyph (
        .seg_n  (seg_s[6:0]),
        .nibble (dec_nib_s),
        .err    (dec_err_s)
    );

    logic [4*NUM_DIGITS-1:0] cap_hex_r;
    logic [NUM_DIGITS-1:0]   cap_dot_r;
    logic [NUM_DIGITS-1:0]   cap_err_r;
    logic [NUM_DIGITS-1:0]   seen_r;
    logic [4*NUM_DIGITS-1:0] cap_hex_next_s;
    logic [NUM_DIGITS-1:0]   cap_dot_next_s;
    logic [NUM_DIGITS-1:0]   cap_err_next_s;
    logic [NUM_DIGITS-1:0]   seen_next_s;
    logic                    frame_done_s;

    // Merge this cycle's capture so a completing frame loads its final digit too
    always_comb begin
        cap_hex_next_s = cap_hex_r;
        cap_dot_next_s = cap_dot_r;
        cap_err_next_s = cap_err_r;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (cap_oh_s[d]) begin
                cap_hex_next_s[4*d +: 4] = dec_nib_s;
                cap_dot_next_s[d]        = ~seg_s[7];
                cap_err_next_s[d]        = dec_err_s;
            end else begin
                cap_hex_next_s[4*d +: 4] = cap_hex_r[4*d +: 4];
                cap_dot_next_s[d]        = cap_dot_r[d];
                cap_err_next_s[d]        = cap_err_r[d];
            end
        end
        frame_done_s = &(seen_r | cap_oh_s);
        if (frame_done_s) begin
            seen_next_s = '0;
        end else begin
            seen_next_s = seen_r | cap_oh_s;
        end
    end

    // Per-digit capture registers and seen mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_hex_r <= '0;
            cap_dot_r <= '0;
            cap_err_r <= '0;
            seen_r    <= '0;
        end else begin
            cap_hex_r <= cap_hex_next_s;
            cap_dot_r <= cap_dot_next_s;
            cap_err_r <= cap_err_next_s;
            seen_r    <= seen_next_s;
        end
    end

    // Output frame and handshake; a frame completing while one is still held is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_hex   <= '0;
            out_dot   <= '0;
            out_err   <= '0;
            overrun   <= 1'b0;
        end else if (frame_done_s) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_hex   <= cap_hex_next_s;
                out_dot   <= cap_dot_next_s;
                out_err   <= cap_err_next_s;
            end else begin
                overrun   <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (8 digits, 4-cycle stability).
module tb_seg7_scan_decoder;

`ifdef SEG7_DEC_SYNC_EN
    localparam int EXP_LAT = 6;
`else
    localparam int EXP_LAT = 4;
`endif

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk;
    logic        rst;
    logic [7:0]  seg_n;
    logic [7:0]  an_n;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_hex;
    logic [7:0]  out_dot;
    logic [7:0]  out_err;
    logic        overrun;

    int tests_run;
    int tests_failed;

    seg7_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hex   (out_hex),
        .out_dot   (out_dot),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] v, input logic dot);
        return {~dot, GLYPH[v]};
    endfunction

    task automatic show(input int d, input logic [7:0] seg, input int n);
        an_n    = 8'hFF;
        an_n[d] = 1'b0;
        seg_n   = seg;
        repeat (n) cycle();
    endtask

    task automatic blank(input int n);
        an_n  = 8'hFF;
        seg_n = 8'hFF;
        repeat (n) cycle();
    endtask

    task automatic send_frame(input logic [31:0] hexv, input logic [7:0] dotv,
                              input int first, input int last);
        for (int d = first; d <= last; d++) begin
            show(d, seg_of(hexv[4*d +: 4], dotv[d]), 6);
            blank(2);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests_run++; if (out_hex !== 32'h0) begin tests_failed++; $display("FAIL reset_hex got %h want 0", out_hex); end
        tests_run++; if (out_dot !== 8'h00 || out_err !== 8'h00) begin tests_failed++; $display("FAIL reset_dot_err got %h/%h want 00/00", out_dot, out_err); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_basic_frame();
        int n;
        send_frame(32'h87654321, 8'h00, 0, 6);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        show(7, seg_of(4'h8, 1'b0), 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        tests_run++; if (n != EXP_LAT) begin tests_failed++; $display("FAIL basic_latency got %0d want %0d", n, EXP_LAT); end
        blank(2);
        tests_run++; if (out_hex !== 32'h87654321) begin tests_failed++; $display("FAIL basic_hex got %h want 87654321", out_hex); end
        tests_run++; if (out_dot !== 8'h00 || out_err !== 8'h00) begin tests_failed++; $display("FAIL basic_dot_err got %h/%h want 00/00", out_dot, out_err); end
        blank(5);
        tests_run++; if (out_valid !== 1'b1 || out_hex !== 32'h87654321) begin tests_failed++; $display("FAIL basic_hold got %b/%h want 1/87654321", out_valid, out_hex); end
        accept();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_accept got %b want 0", out_valid); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL basic_overrun got %b want 0", overrun); end
    endtask

    task automatic test_err_dot();
        for (int d = 0; d < 8; d++) begin
            if (d == 3)      show(d, 8'hFF, 6);
            else if (d == 5) show(d, 8'h12, 6);
            else             show(d, seg_of(4'(d), 1'b0), 6);
            blank(2);
        end
        wait_valid();
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL errdot_valid got %b want 1", out_valid); end
        tests_run++; if (out_err !== 8'h08) begin tests_failed++; $display("FAIL errdot_err got %h want 08", out_err); end
        tests_run++; if (out_dot !== 8'h20) begin tests_failed++; $display("FAIL errdot_dot got %h want 20", out_dot); end
        tests_run++; if (out_hex !== 32'h76540210) begin tests_failed++; $display("FAIL errdot_hex got %h want 76540210", out_hex); end
        accept();
    endtask

    task automatic test_glitch();
        send_frame(32'h76543210, 8'h00, 1, 7);
        an_n  = 8'hFC;
        seg_n = 8'hC0;
        repeat (10) cycle();
        blank(2);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL glitch_twolow got %b want 0", out_valid); end
        show(0, 8'hC0, 3);
        show(0, 8'hF9, 4);
        blank(2);
        wait_valid();
        tests_run++; if (out_valid !== 1'b1 || out_hex !== 32'h76543211) begin tests_failed++; $display("FAIL glitch_hex got %b/%h want 1/76543211", out_valid, out_hex); end
        accept();
    endtask

    task automatic test_overrun();
        send_frame(32'h87654321, 8'h00, 0, 7);
        wait_valid();
        send_frame(32'h89ABCDEF, 8'h00, 0, 7);
        blank(2);
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got %b want 1", overrun); end
        tests_run++; if (out_valid !== 1'b1 || out_hex !== 32'h87654321) begin tests_failed++; $display("FAIL ovr_hold got %b/%h want 1/87654321", out_valid, out_hex); end
        accept();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_accept got %b want 0", out_valid); end
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(32'h01234567, 8'h00, 0, 7);
        wait_valid();
        tests_run++; if (out_hex !== 32'h01234567) begin tests_failed++; $display("FAIL b2b_first got %h want 01234567", out_hex); end
        send_frame(32'hFEDCBA98, 8'h00, 0, 6);
        show(7, seg_of(4'hF, 1'b0), EXP_LAT - 1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        blank(2);
        tests_run++; if (out_valid !== 1'b1 || out_hex !== 32'hFEDCBA98) begin tests_failed++; $display("FAIL b2b_load got %b/%h want 1/fedcba98", out_valid, out_hex); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun got %b want 0", overrun); end
        send_frame(32'h13572468, 8'h00, 0, 3);
        show(4, seg_of(4'h7, 1'b0), 2);
        rst = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0 || out_hex !== 32'h0) begin tests_failed++; $display("FAIL rst_async got %b/%h want 0/0", out_valid, out_hex); end
        cycle();
        rst = 1'b0;
        blank(2);
        send_frame(32'h13572468, 8'h00, 4, 7);
        blank(10);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_partial got %b want 0", out_valid); end
        send_frame(32'h13572468, 8'h00, 0, 3);
        wait_valid();
        tests_run++; if (out_valid !== 1'b1 || out_hex !== 32'h13572468) begin tests_failed++; $display("FAIL rst_refill got %b/%h want 1/13572468", out_valid, out_hex); end
        accept();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        seg_n        = 8'hFF;
        an_n         = 8'hFF;
        out_ready    = 1'b0;
        test_reset();
        test_basic_frame();
        test_err_dot();
        test_glitch();
        test_overrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
